prvp_spi_slave: RTL and testbench

Single-lane SPI target (mode 0: CPOL=0, CPHA=0) that terminates transfers driven by the team's SPI master. It oversamples the SPI pins in the HCLK domain and decodes an 8-bit command followed by a stream of 32-bit words. Received words go out on a valid/ready stream; transmitted words are pulled from a valid/ready stream. It sits beside the peripheral FIFOs, in the same place the master's FIFOs sit on the other end.

---
 rtl/prvp_spi_slave_pkg.sv | 33 +++
 rtl/prvp_spi_slave_sync.sv | 32 +++
 rtl/prvp_spi_slave.sv | 206 ++++++++++++++++++++
 tb/tb_prvp_spi_slave.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prvp_spi_slave_pkg.sv
// Shared types and constants for the SPI target.
package prvp_spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdData,
    StSta,
    StIgnore
  } state_e;

  localparam logic [7:0] DEF_CMD_WR  = 8'h02;
  localparam logic [7:0] DEF_CMD_RD  = 8'h0B;
  localparam logic [7:0] DEF_CMD_STA = 8'h05;

  // Status byte bit positions
  localparam int unsigned STA_OVF = 1;
  localparam int unsigned STA_UDF = 0;

  // events_o bit positions
  localparam int unsigned EV_EOT = 0;
  localparam int unsigned EV_ERR = 1;

  function automatic logic [7:0] status_byte(input logic ovf, input logic udf);
    logic [7:0] b;
    b          = '0;
    b[STA_OVF] = ovf;
    b[STA_UDF] = udf;
    return b;
  endfunction

endpackage

// File: rtl/prvp_spi_slave_sync.sv
// N-stage synchroniser with rise/fall detection on the synchronised value.
module prvp_spi_slave_sync #(
  parameter int unsigned STAGES    = 2,  // must be at least 2
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the asynchronous input through the chain; keep the previous sample for edge detect
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/prvp_spi_slave.sv
// SPI mode-0 target: 8-bit command then a stream of 32-bit words, oversampled in HCLK.
module prvp_spi_slave
  import prvp_spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WR      = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RD      = DEF_CMD_RD,
  parameter logic [7:0]  CMD_STA     = DEF_CMD_STA
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        spi_clk_i,
  input  logic        spi_csn_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [1:0]  events_o
);

  logic clk_rise, clk_fall, csn_s, csn_rise, sdi_s;
  logic unused_clk_q, unused_csn_fall, unused_sdi_rise, unused_sdi_fall;

  prvp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .d_i    (spi_clk_i),
    .q_o    (unused_clk_q),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  // csn idles high, so its chain resets high to avoid a spurious select after reset
  prvp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .d_i    (spi_csn_i),
    .q_o    (csn_s),
    .rise_o (csn_rise),
    .fall_o (unused_csn_fall)
  );

  prvp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .d_i    (spi_sdi_i),
    .q_o    (sdi_s),
    .rise_o (unused_sdi_rise),
    .fall_o (unused_sdi_fall)
  );

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q;
  logic [30:0] rx_sh_q;
  logic [31:0] tx_sh_q;
  logic        sdo_q, sta_done_q;
  logic [31:0] rx_data_q;
  logic        rx_valid_q, ovf_q, udf_q;
  logic [1:0]  events_q;

  logic        fetch, load_sta, word_done;
  logic        last_cmd_bit, last_word_bit;
  logic [7:0]  cmd_byte;

  assign cmd_byte      = {rx_sh_q[6:0], sdi_s};
  assign last_cmd_bit  = (bit_cnt_q == 5'd7);
  assign last_word_bit = (bit_cnt_q == 5'd31);

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle strobes; a csn rise overrides any coincident clock edge
  always_comb begin
    state_d   = state_q;
    fetch     = 1'b0;
    load_sta  = 1'b0;
    word_done = 1'b0;
    if (csn_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!csn_s) state_d = StCmd;
        end
        StCmd: begin
          if (clk_rise && last_cmd_bit) begin
            if (cmd_byte == CMD_WR) begin
              state_d = StWrData;
            end else if (cmd_byte == CMD_RD) begin
              state_d = StRdData;
              fetch   = 1'b1;
            end else if (cmd_byte == CMD_STA) begin
              state_d  = StSta;
              load_sta = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StWrData: word_done = clk_rise && last_word_bit;
        StRdData: fetch     = clk_rise && last_word_bit;
        StSta, StIgnore: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Shift registers, counters, rx holding register, sticky flags and event pulses
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      sdo_q      <= 1'b0;
      sta_done_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      events_q   <= '0;
    end else begin
      events_q <= '0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      if (csn_rise) begin
        bit_cnt_q        <= '0;
        rx_sh_q          <= '0;
        tx_sh_q          <= '0;
        sdo_q            <= 1'b0;
        sta_done_q       <= 1'b0;
        events_q[EV_EOT] <= (state_q != StIdle);
        // Flags clear only once the host has seen the whole status byte
        if (sta_done_q) begin
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end
      end else begin
        if (clk_rise) begin
          if (state_q == StCmd) begin
            rx_sh_q   <= {rx_sh_q[29:0], sdi_s};
            bit_cnt_q <= last_cmd_bit ? 5'd0 : bit_cnt_q + 5'd1;
          end
          if (state_q == StWrData) begin
            rx_sh_q   <= {rx_sh_q[29:0], sdi_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
          if (state_q == StRdData) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
          if (state_q == StSta && !sta_done_q) begin
            bit_cnt_q  <= last_cmd_bit ? 5'd0 : bit_cnt_q + 5'd1;
            sta_done_q <= last_cmd_bit;
          end
        end

        // Zeros shift in behind the data, so sdo reads 0 once the status byte is out
        if (clk_fall && (state_q == StRdData || state_q == StSta)) begin
          sdo_q   <= tx_sh_q[31];
          tx_sh_q <= {tx_sh_q[30:0], 1'b0};
        end

        if (load_sta) tx_sh_q <= {status_byte(ovf_q, udf_q), 24'h0};

        if (fetch) begin
          if (tx_valid_i) begin
            tx_sh_q <= tx_data_i;
          end else begin
            tx_sh_q          <= '0;
            udf_q            <= 1'b1;
            events_q[EV_ERR] <= 1'b1;
          end
        end

        if (word_done) begin
          if (rx_valid_q && !rx_ready_i) begin
            ovf_q            <= 1'b1;
            events_q[EV_ERR] <= 1'b1;
          end else begin
            rx_data_q  <= {rx_sh_q, sdi_s};
            rx_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_sdo_oe_o = (state_q == StRdData) || (state_q == StSta && !sta_done_q);
  assign spi_sdo_o    = spi_sdo_oe_o & sdo_q;
  assign tx_ready_o   = fetch & tx_valid_i;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign events_o     = events_q;

endmodule

// File: tb/tb_prvp_spi_slave.sv
// Directed bench for prvp_spi_slave acting as the SPI master and stream endpoints.
module tb_prvp_spi_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_csn_i = 1'b1;
  logic        spi_sdi_i = 1'b0;
  logic        spi_sdo_o, spi_sdo_oe_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [31:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [1:0]  events_o;

  int checks = 0;
  int failures = 0;

  // Monitor counters
  int          rx_cnt = 0;
  int          tx_pops = 0;
  int          ev0_cnt = 0;
  int          ev1_cnt = 0;
  int          oe_cnt = 0;
  logic [31:0] rx_log [16];

  // Transmit source: words tx_words[0..tx_cnt-1], advanced by each pop
  logic [31:0] tx_words [4];
  int          tx_base = 0;
  int          tx_cnt = 0;
  int          tx_idx;
  assign tx_idx     = tx_pops - tx_base;
  assign tx_valid_i = (tx_idx < tx_cnt);
  assign tx_data_i  = tx_valid_i ? tx_words[tx_idx[1:0]] : 32'h0;

  prvp_spi_slave dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .spi_clk_i   (spi_clk_i),
    .spi_csn_i   (spi_csn_i),
    .spi_sdi_i   (spi_sdi_i),
    .spi_sdo_o   (spi_sdo_o),
    .spi_sdo_oe_o(spi_sdo_oe_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .events_o    (events_o)
  );

  always #5 HCLK = ~HCLK;

  // Count handshakes and pulses away from the active edge
  always @(negedge HCLK) begin
    if (rx_valid_o && rx_ready_i) begin
      rx_log[rx_cnt % 16] = rx_data_o;
      rx_cnt++;
    end
    if (events_o[0]) ev0_cnt++;
    if (events_o[1]) ev1_cnt++;
    if (spi_sdo_oe_o) oe_cnt++;
  end

  // Advance the transmit source only after the DUT has loaded the popped word
  always @(negedge HCLK) begin
    if (tx_ready_o) begin
      @(posedge HCLK);
      #1;
      tx_pops++;
    end
  end

  task automatic spi_begin();
    spi_csn_i = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #50;
    spi_csn_i = 1'b1;
    #300;
  endtask

  // Mode 0: drive MOSI while SCK low, sample MISO at the rising edge
  task automatic spi_bits(input logic [31:0] mosi, input int n, output logic [31:0] miso,
                          output int oe_hi);
    miso  = '0;
    oe_hi = 0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi_i = mosi[i];
      #50;
      spi_clk_i = 1'b1;
      miso = {miso[30:0], spi_sdo_o};
      if (spi_sdo_oe_o) oe_hi++;
      #50;
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    tx_words[0] = 32'h1234_5678;
    tx_base = tx_pops;
    tx_cnt = 1;
    #47;
    checks++;
    if (rx_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_o);
    end
    checks++;
    if (rx_data_o !== 32'h0) begin
      failures++; $display("FAIL reset_rx_data got=%h exp=00000000", rx_data_o);
    end
    checks++;
    if ({spi_sdo_o, spi_sdo_oe_o, tx_ready_o} !== 3'b000) begin
      failures++; $display("FAIL reset_sdo_oe_txrdy got=%b exp=000",
                           {spi_sdo_o, spi_sdo_oe_o, tx_ready_o});
    end
    checks++;
    if (events_o !== 2'b00) begin
      failures++; $display("FAIL reset_events got=%b exp=00", events_o);
    end
    tx_cnt = 0;
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    #100;
  endtask

  task automatic test_write();
    int r0, e0, e1, oe, oe_sum;
    logic [31:0] m;
    rx_ready_i = 1'b1;
    r0 = rx_cnt; e0 = ev0_cnt; e1 = ev1_cnt;
    spi_begin();
    spi_bits(32'h02, 8, m, oe);
    oe_sum = oe;
    spi_bits(32'hDEAD_BEEF, 32, m, oe);
    oe_sum += oe;
    spi_bits(32'h1234_5678, 32, m, oe);
    oe_sum += oe;
    spi_end();
    checks++;
    if (rx_cnt - r0 !== 2) begin
      failures++; $display("FAIL write_count got=%0d exp=2", rx_cnt - r0);
    end
    checks++;
    if (rx_log[r0 % 16] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL write_word0 got=%h exp=deadbeef", rx_log[r0 % 16]);
    end
    checks++;
    if (rx_log[(r0 + 1) % 16] !== 32'h1234_5678) begin
      failures++; $display("FAIL write_word1 got=%h exp=12345678", rx_log[(r0 + 1) % 16]);
    end
    checks++;
    if (ev0_cnt - e0 !== 1) begin
      failures++; $display("FAIL write_eot got=%0d exp=1", ev0_cnt - e0);
    end
    checks++;
    if (ev1_cnt - e1 !== 0) begin
      failures++; $display("FAIL write_err got=%0d exp=0", ev1_cnt - e1);
    end
    checks++;
    if (oe_sum !== 0) begin
      failures++; $display("FAIL write_oe got=%0d exp=0", oe_sum);
    end
  endtask

  task automatic test_read();
    int p0, e0, oe_cmd, oe0, oe1;
    logic [31:0] m, m0, m1;
    tx_words[0] = 32'hA5A5_A5A5;
    tx_words[1] = 32'h0F0F_0F0F;
    tx_base = tx_pops;
    tx_cnt = 2;
    p0 = tx_pops; e0 = ev0_cnt;
    spi_begin();
    spi_bits(32'h0B, 8, m, oe_cmd);
    spi_bits(32'h0, 32, m0, oe0);
    spi_bits(32'h0, 32, m1, oe1);
    spi_end();
    tx_cnt = 0;
    checks++;
    if (m0 !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL read_word0 got=%h exp=a5a5a5a5", m0);
    end
    checks++;
    if (m1 !== 32'h0F0F_0F0F) begin
      failures++; $display("FAIL read_word1 got=%h exp=0f0f0f0f", m1);
    end
    checks++;
    if (tx_pops - p0 !== 2) begin
      failures++; $display("FAIL read_pops got=%0d exp=2", tx_pops - p0);
    end
    checks++;
    if (oe_cmd !== 0 || oe0 !== 32 || oe1 !== 32) begin
      failures++; $display("FAIL read_oe got=%0d/%0d/%0d exp=0/32/32", oe_cmd, oe0, oe1);
    end
    checks++;
    if (spi_sdo_oe_o !== 1'b0) begin
      failures++; $display("FAIL read_oe_after got=%b exp=0", spi_sdo_oe_o);
    end
    checks++;
    if (ev0_cnt - e0 !== 1) begin
      failures++; $display("FAIL read_eot got=%0d exp=1", ev0_cnt - e0);
    end
  endtask

  task automatic test_underflow_status();
    int e1, p0, oe;
    logic [31:0] m;
    tx_base = tx_pops;
    tx_cnt = 0;
    e1 = ev1_cnt; p0 = tx_pops;
    spi_begin();
    spi_bits(32'h0B, 8, m, oe);
    spi_bits(32'h0, 32, m, oe);
    spi_end();
    checks++;
    if (m !== 32'h0) begin
      failures++; $display("FAIL udf_miso got=%h exp=00000000", m);
    end
    // Empty fetches at the command and again after the 32nd data bit
    checks++;
    if (ev1_cnt - e1 !== 2) begin
      failures++; $display("FAIL udf_err_pulses got=%0d exp=2", ev1_cnt - e1);
    end
    checks++;
    if (tx_pops - p0 !== 0) begin
      failures++; $display("FAIL udf_pops got=%0d exp=0", tx_pops - p0);
    end
    spi_begin();
    spi_bits(32'h05, 8, m, oe);
    spi_bits(32'h0, 8, m, oe);
    spi_end();
    checks++;
    if (m[7:0] !== 8'h01) begin
      failures++; $display("FAIL status_udf got=%h exp=01", m[7:0]);
    end
    checks++;
    if (oe !== 8) begin
      failures++; $display("FAIL status_oe got=%0d exp=8", oe);
    end
    spi_begin();
    spi_bits(32'h05, 8, m, oe);
    spi_bits(32'h0, 8, m, oe);
    spi_end();
    checks++;
    if (m[7:0] !== 8'h00) begin
      failures++; $display("FAIL status_cleared got=%h exp=00", m[7:0]);
    end
  endtask

  task automatic test_overflow();
    int r0, e1, oe;
    logic [31:0] m;
    rx_ready_i = 1'b0;
    r0 = rx_cnt; e1 = ev1_cnt;
    spi_begin();
    spi_bits(32'h02, 8, m, oe);
    spi_bits(32'h1111_1111, 32, m, oe);
    spi_bits(32'h2222_2222, 32, m, oe);
    spi_bits(32'h3333_3333, 32, m, oe);
    spi_end();
    checks++;
    if (ev1_cnt - e1 !== 2) begin
      failures++; $display("FAIL ovf_err_pulses got=%0d exp=2", ev1_cnt - e1);
    end
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h1111_1111) begin
      failures++; $display("FAIL ovf_held got=%b/%h exp=1/11111111", rx_valid_o, rx_data_o);
    end
    spi_begin();
    spi_bits(32'h05, 8, m, oe);
    spi_bits(32'h0, 8, m, oe);
    spi_end();
    checks++;
    if (m[7:0] !== 8'h02) begin
      failures++; $display("FAIL status_ovf got=%h exp=02", m[7:0]);
    end
    rx_ready_i = 1'b1;
    #50;
    checks++;
    if (rx_cnt - r0 !== 1 || rx_log[r0 % 16] !== 32'h1111_1111) begin
      failures++; $display("FAIL ovf_drain got=%0d/%h exp=1/11111111", rx_cnt - r0,
                           rx_log[r0 % 16]);
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin
      failures++; $display("FAIL ovf_drained_valid got=%b exp=0", rx_valid_o);
    end
  endtask

  task automatic test_abort();
    int r0, e0, oe;
    logic [31:0] m;
    rx_ready_i = 1'b1;
    r0 = rx_cnt; e0 = ev0_cnt;
    spi_begin();
    spi_bits(32'h02, 8, m, oe);
    spi_bits(32'h1ABC, 13, m, oe);
    spi_end();
    checks++;
    if (rx_cnt - r0 !== 0) begin
      failures++; $display("FAIL abort_no_rx got=%0d exp=0", rx_cnt - r0);
    end
    checks++;
    if (ev0_cnt - e0 !== 1) begin
      failures++; $display("FAIL abort_eot got=%0d exp=1", ev0_cnt - e0);
    end
    spi_begin();
    spi_bits(32'h02, 8, m, oe);
    spi_bits(32'h0000_0001, 32, m, oe);
    spi_end();
    checks++;
    if (rx_cnt - r0 !== 1 || rx_log[r0 % 16] !== 32'h0000_0001) begin
      failures++; $display("FAIL abort_next_word got=%0d/%h exp=1/00000001", rx_cnt - r0,
                           rx_log[r0 % 16]);
    end
  endtask

  task automatic test_unknown_cmd();
    int r0, p0, o0, e0, oe;
    logic [31:0] m;
    tx_words[0] = 32'hCAFE_F00D;
    tx_base = tx_pops;
    tx_cnt = 1;
    r0 = rx_cnt; p0 = tx_pops; o0 = oe_cnt; e0 = ev0_cnt;
    spi_begin();
    spi_bits(32'h9F, 8, m, oe);
    spi_bits(32'hFFFF_FFFF, 32, m, oe);
    spi_bits(32'hFF, 8, m, oe);
    spi_end();
    tx_cnt = 0;
    checks++;
    if (oe_cnt - o0 !== 0) begin
      failures++; $display("FAIL unk_oe got=%0d exp=0", oe_cnt - o0);
    end
    checks++;
    if (rx_cnt - r0 !== 0 || tx_pops - p0 !== 0) begin
      failures++; $display("FAIL unk_handshakes got=%0d/%0d exp=0/0", rx_cnt - r0, tx_pops - p0);
    end
    checks++;
    if (ev0_cnt - e0 !== 1) begin
      failures++; $display("FAIL unk_eot got=%0d exp=1", ev0_cnt - e0);
    end
  endtask

  task automatic test_async_reset();
    int oe;
    logic [31:0] m;
    rx_ready_i = 1'b0;
    spi_begin();
    spi_bits(32'h02, 8, m, oe);
    spi_bits(32'h55AA_55AA, 32, m, oe);
    spi_bits(32'h7, 5, m, oe);
    checks++;
    if (rx_valid_o !== 1'b1) begin
      failures++; $display("FAIL arst_pending got=%b exp=1", rx_valid_o);
    end
    #3;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (rx_valid_o !== 1'b0 || rx_data_o !== 32'h0) begin
      failures++; $display("FAIL arst_rx got=%b/%h exp=0/00000000", rx_valid_o, rx_data_o);
    end
    checks++;
    if ({spi_sdo_oe_o, events_o} !== 3'b000) begin
      failures++; $display("FAIL arst_outputs got=%b exp=000", {spi_sdo_oe_o, events_o});
    end
    spi_csn_i = 1'b1;
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    #100;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_underflow_status();
    test_overflow();
    test_abort();
    test_unknown_cmd();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
